// File: rtl/branch_hazard_ctrl_if.sv
// branch_hazard_ctrl_if: ID-stage branch hazard signals between the pipeline and the hazard controller.
interface branch_hazard_ctrl_if;
  logic        id_is_beq;
  logic        id_is_bne;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        mem_regwrite;
  logic        mem_memread;
  logic [4:0]  mem_rd;
  logic        branch_equal;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        pc_src;
  logic [15:0] stall_cycles;
  logic [15:0] branch_flushes;
  modport master (
    output id_is_beq, id_is_bne, id_rs, id_rt, ex_regwrite, ex_memread, ex_rd,
           mem_regwrite, mem_memread, mem_rd, branch_equal,
    input  fwd_a_sel, fwd_b_sel, pc_write, ifid_write, idex_bubble, ifid_flush, pc_src,
           stall_cycles, branch_flushes
  );
  modport slave (
    input  id_is_beq, id_is_bne, id_rs, id_rt, ex_regwrite, ex_memread, ex_rd,
           mem_regwrite, mem_memread, mem_rd, branch_equal,
    output fwd_a_sel, fwd_b_sel, pc_write, ifid_write, idex_bubble, ifid_flush, pc_src,
           stall_cycles, branch_flushes
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: stalls ID-stage branches on EX/MEM producers, selects branch operand forwarding and resolves.
module branch_hazard_ctrl (
  input logic clk,
  input logic rst_n,
  branch_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;
  state_t state_q, state_d;
  logic [15:0] stall_cycles_q, stall_cycles_d, branch_flushes_q, branch_flushes_d;
  logic branch, ex_hit, mem_load_hit, taken, stall, resolve;
  logic ex_a, ex_b, mem_a, mem_b;
  logic [1:0] need;
  always_comb begin
    branch       = bus.id_is_beq | bus.id_is_bne;
    ex_a         = bus.id_rs != 5'd0 && bus.id_rs == bus.ex_rd;
    ex_b         = bus.id_rt != 5'd0 && bus.id_rt == bus.ex_rd;
    mem_a        = bus.id_rs != 5'd0 && bus.id_rs == bus.mem_rd;
    mem_b        = bus.id_rt != 5'd0 && bus.id_rt == bus.mem_rd;
    ex_hit       = bus.ex_regwrite & (ex_a | ex_b);
    mem_load_hit = bus.mem_regwrite & bus.mem_memread & (mem_a | mem_b);
    need         = !branch ? 2'd0 : ex_hit & bus.ex_memread ? 2'd2 : ex_hit | mem_load_hit ? 2'd1 : 2'd0;
    taken        = (bus.id_is_beq & bus.branch_equal) | (bus.id_is_bne & ~bus.branch_equal);
    // Outputs are gated by rst_n so a branch on the inputs cannot leak through during reset.
    stall        = rst_n & (state_q == STALL || (state_q == IDLE && need != 2'd0));
    resolve      = rst_n & (state_q == RESOLVE || (state_q == IDLE && branch && need == 2'd0));
    state_d      = state_q == IDLE ? (need == 2'd2 ? STALL : need == 2'd1 ? RESOLVE : IDLE)
                 : state_q == STALL ? RESOLVE : IDLE;
    bus.fwd_a_sel   = {1'b0, resolve & bus.mem_regwrite & ~bus.mem_memread & mem_a};
    bus.fwd_b_sel   = {1'b0, resolve & bus.mem_regwrite & ~bus.mem_memread & mem_b};
    bus.pc_write    = ~stall;
    bus.ifid_write  = ~stall;
    bus.idex_bubble = stall;
    bus.ifid_flush  = resolve & taken;
    bus.pc_src      = resolve & taken;
    stall_cycles_d   = stall_cycles_q + {15'd0, stall && stall_cycles_q != 16'hFFFF};
    branch_flushes_d = branch_flushes_q + {15'd0, resolve && taken && branch_flushes_q != 16'hFFFF};
    bus.stall_cycles   = stall_cycles_q;
    bus.branch_flushes = branch_flushes_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      stall_cycles_q   <= 16'd0;
      branch_flushes_q <= 16'd0;
    end else begin
      state_q          <= state_d;
      stall_cycles_q   <= stall_cycles_d;
      branch_flushes_q <= branch_flushes_d;
    end
  end
endmodule
